sram_operand_fetch: RTL and testbench

Sequencer between the 16-entry half-precision operand SRAM and the FPMAC pipeline input. On `start`, it reads consecutive address pairs from the SRAM: the even offset becomes operand A and the odd offset becomes operand B. Each pair is presented to the FPMAC with a valid/ready handshake. It raises `done` after the programmed number of pairs has been accepted.

---
 rtl/fpmac_pkg.sv | 18 +
 rtl/sram_operand_fetch_if.sv | 33 +++
 rtl/sram_operand_fetch.sv | 134 +++++++++++++
 tb/tb_sram_operand_fetch.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fpmac_pkg.sv
// Shared definitions for the FPMAC datapath: operand format, SRAM geometry
// and the operand-fetch sequencer states.
package fpmac_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    typedef logic [DATA_W-1:0] fp16_t;

    typedef enum logic [2:0] {
        IDLE,
        READ_A,
        READ_B,
        SEND,
        DONE
    } fetch_state_e;

endpackage

// File: rtl/sram_operand_fetch_if.sv
// Bus bundle between the operand fetcher, the operand SRAM and the FPMAC input.
// The master side is the fetcher; the slave side is the SRAM plus FPMAC.
interface sram_operand_fetch_if #(
    parameter int DATA_W = fpmac_pkg::DATA_W,
    parameter int ADDR_W = fpmac_pkg::ADDR_W
);

    logic              mem_readEn;
    logic              mem_writeEn;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_readData;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_valid;
    logic              op_ready;
    logic              op_last;

    modport master (
        output mem_readEn, mem_writeEn, mem_address,
        input  mem_readData,
        output op_a, op_b, op_valid, op_last,
        input  op_ready
    );

    modport slave (
        input  mem_readEn, mem_writeEn, mem_address,
        output mem_readData,
        input  op_a, op_b, op_valid, op_last,
        output op_ready
    );

endinterface

// File: rtl/sram_operand_fetch.sv
// Walks consecutive SRAM address pairs from a latched base address and hands
// each (even, odd) word pair to the FPMAC over a valid/ready handshake.
module sram_operand_fetch #(
    parameter int DATA_W    = fpmac_pkg::DATA_W,
    parameter int ADDR_W    = fpmac_pkg::ADDR_W,
    parameter int NUM_PAIRS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    sram_operand_fetch_if.master bus
);

    import fpmac_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NUM_PAIRS - 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic              op_valid_q, op_valid_d;
    logic              op_last_q, op_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              read_en_q, read_en_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [ADDR_W-1:0] pair_base;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        k_d     = k_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;

        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        base_d  = base_addr;
                        k_d     = '0;
                        state_d = READ_A;
                    end
                end
                READ_A: begin
                    op_a_d  = bus.mem_readData;
                    state_d = READ_B;
                end
                READ_B: begin
                    op_b_d  = bus.mem_readData;
                    state_d = SEND;
                end
                SEND: begin
                    if (bus.op_ready) begin
                        if (op_last_q) begin
                            state_d = DONE;
                        end else begin
                            k_d     = k_q + ADDR_W'(1);
                            state_d = READ_A;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they leave a flop and
        // carry no combinational path from op_ready.
        pair_base  = base_d + (k_d << 1);
        op_valid_d = (state_d == SEND);
        op_last_d  = (state_d == SEND) && (k_d == LAST_K);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        read_en_d  = (state_d == READ_A) || (state_d == READ_B);
        address_d  = '0;
        if (state_d == READ_A) begin
            address_d = pair_base;
        end else if (state_d == READ_B) begin
            address_d = pair_base + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            k_q        <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            op_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            read_en_q  <= 1'b0;
            address_q  <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            k_q        <= k_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
            op_last_q  <= op_last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            read_en_q  <= read_en_d;
            address_q  <= address_d;
        end
    end

    assign bus.mem_readEn  = read_en_q;
    assign bus.mem_writeEn = 1'b0;
    assign bus.mem_address = address_q;
    assign bus.op_a        = op_a_q;
    assign bus.op_b        = op_b_q;
    assign bus.op_valid    = op_valid_q;
    assign bus.op_last     = op_last_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_sram_operand_fetch.sv
// Self-checking bench for sram_operand_fetch: directed runs plus random
// backpressure, compared against a cycle-level model of pair timing.
module tb_sram_operand_fetch;

    localparam int N = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  base_addr = 4'd0;
    logic        busy;
    logic        done;
    logic [15:0] sram [16];

    int checks = 0;
    int errors = 0;

    sram_operand_fetch_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    sram_operand_fetch #(.DATA_W(16), .ADDR_W(4), .NUM_PAIRS(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    // Combinational SRAM read port holding the init image.
    assign bus.mem_readData = bus.mem_readEn ? sram[bus.mem_address] : 16'h0000;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_valid"}, 32'(bus.op_valid), 0);
        checkOutput({tag, "_last"}, 32'(bus.op_last), 0);
        checkOutput({tag, "_readEn"}, 32'(bus.mem_readEn), 0);
        checkOutput({tag, "_writeEn"}, 32'(bus.mem_writeEn), 0);
        checkOutput({tag, "_addr"}, 32'(bus.mem_address), 0);
    endtask

    // One run from start. readyMode 0: always ready, 1: random ready,
    // 2: five stall cycles on the second pair. restartCyc re-pulses start
    // mid-run; abortPair aborts while that pair index is being offered.
    task automatic applyStimulus(input logic [3:0] base, input int readyMode,
                                 input int restartCyc, input int abortPair);
        int         cyc = 0;
        int         pairIdx = 0;
        int         nextValid = 3;
        int         doneCyc = 0;
        int         stallLeft = 5;
        logic       aborted = 1'b0;
        logic       expRdA, expRdB, expValid, expBusy, expDone;
        logic [3:0] expAddr;

        @(negedge clock);
        start         = 1'b1;
        base_addr     = base;
        bus.op_ready  = 1'b0;
        while (1) begin
            @(negedge clock);
            cyc++;
            start = (cyc == restartCyc);
            abort = 1'b0;
            if (aborted) begin
                checkIdleOutputs("afterAbort");
                checkOutput("abortHoldA", 32'(bus.op_a), 32'(sram[4'(base + 2 * abortPair)]));
                checkOutput("abortHoldB", 32'(bus.op_b), 32'(sram[4'(base + 2 * abortPair + 1)]));
                break;
            end
            if (cyc > 300) begin
                checks++;
                errors++;
                $error("[TB] FAIL runTimeout: observed %0d cycles, expected done within 300", cyc);
                break;
            end

            expRdA   = (pairIdx < N) && (cyc == nextValid - 2);
            expRdB   = (pairIdx < N) && (cyc == nextValid - 1);
            expValid = (pairIdx < N) && (cyc >= nextValid);
            expBusy  = (pairIdx < N) || (cyc <= doneCyc);
            expDone  = (doneCyc != 0) && (cyc == doneCyc);
            expAddr  = expRdA ? 4'(base + 2 * pairIdx) :
                       expRdB ? 4'(base + 2 * pairIdx + 1) : 4'd0;

            checkOutput("readEn", 32'(bus.mem_readEn), 32'(expRdA || expRdB));
            checkOutput("address", 32'(bus.mem_address), 32'(expAddr));
            checkOutput("writeEn", 32'(bus.mem_writeEn), 0);
            checkOutput("valid", 32'(bus.op_valid), 32'(expValid));
            checkOutput("last", 32'(bus.op_last), 32'(expValid && (pairIdx == N - 1)));
            checkOutput("busy", 32'(busy), 32'(expBusy));
            checkOutput("done", 32'(done), 32'(expDone));
            if (expValid) begin
                checkOutput("opA", 32'(bus.op_a), 32'(sram[4'(base + 2 * pairIdx)]));
                checkOutput("opB", 32'(bus.op_b), 32'(sram[4'(base + 2 * pairIdx + 1)]));
            end

            if (pairIdx == N && cyc == doneCyc + 1) begin
                if (readyMode == 0 && restartCyc < 0) begin
                    checkOutput("runLength", 32'(cyc), 32'(3 * N + 2));
                end
                break;
            end

            unique case (readyMode)
                1:       bus.op_ready = ($urandom_range(0, 2) != 0);
                2:       bus.op_ready = !(pairIdx == 1 && stallLeft > 0);
                default: bus.op_ready = 1'b1;
            endcase
            if (expValid && pairIdx == 1 && !bus.op_ready) begin
                stallLeft--;
            end

            if (expValid && pairIdx == abortPair) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end else if (expValid && bus.op_ready) begin
                pairIdx++;
                nextValid = cyc + 3;
                if (pairIdx == N) begin
                    doneCyc = cyc + 1;
                end
            end
        end
        bus.op_ready = 1'b0;
    endtask

    initial begin
        sram[0]  = 16'hB800; sram[1]  = 16'hC000; sram[2]  = 16'h3400; sram[3]  = 16'h4400;
        sram[4]  = 16'h3C00; sram[5]  = 16'h4000; sram[6]  = 16'hBC00; sram[7]  = 16'h3800;
        sram[8]  = 16'h4200; sram[9]  = 16'hC200; sram[10] = 16'h3555; sram[11] = 16'h2E66;
        sram[12] = 16'hB400; sram[13] = 16'h4600; sram[14] = 16'h3000; sram[15] = 16'h4800;
        bus.op_ready = 1'b0;

        $display("[TB] reset values");
        repeat (2) @(negedge clock);
        checkIdleOutputs("reset");
        checkOutput("reset_opA", 32'(bus.op_a), 0);
        checkOutput("reset_opB", 32'(bus.op_b), 0);
        reset = 1'b1;
        @(negedge clock);
        checkIdleOutputs("postReset");

        $display("[TB] full run from base 0, ready held high");
        applyStimulus(4'd0, 0, -1, -1);

        $display("[TB] wrap-around from base 14");
        applyStimulus(4'd14, 0, -1, -1);

        $display("[TB] backpressure on pair 2");
        applyStimulus(4'd0, 2, -1, -1);

        $display("[TB] start re-asserted in cycle 4");
        applyStimulus(4'd0, 0, 4, -1);

        $display("[TB] abort on pair 3, then fresh start");
        applyStimulus(4'd0, 0, -1, 2);
        applyStimulus(4'd0, 0, -1, -1);

        $display("[TB] start and abort in the same idle cycle");
        @(negedge clock);
        start = 1'b1;
        abort = 1'b1;
        base_addr = 4'd6;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        checkIdleOutputs("startAbort");
        @(negedge clock);
        checkIdleOutputs("startAbortLater");

        $display("[TB] async reset during READ_B");
        start = 1'b1;
        base_addr = 4'd4;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checkOutput("preReset_readEn", 32'(bus.mem_readEn), 1);
        checkOutput("preReset_addr", 32'(bus.mem_address), 5);
        #2 reset = 1'b0;
        #1;
        checkIdleOutputs("asyncReset");
        checkOutput("asyncReset_opA", 32'(bus.op_a), 0);
        checkOutput("asyncReset_opB", 32'(bus.op_b), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            checkIdleOutputs("afterRelease");
        end

        $display("[TB] random bases with random backpressure");
        for (int r = 0; r < 4; r++) begin
            applyStimulus(4'($urandom_range(0, 15)), 1, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
